// File: rtl/mdu_iter_unit_pkg.sv
// Shared op codes, FSM states and decode helpers for the iterative multiply/divide unit.
package mdu_iter_unit_pkg;

   // Op codes as presented by EX on op_code.
   typedef enum logic [3:0] {
      OpNop   = 4'd0,
      OpMult  = 4'd1,
      OpMultu = 4'd2,
      OpDiv   = 4'd3,
      OpDivu  = 4'd4,
      OpMadd  = 4'd5,
      OpMaddu = 4'd6,
      OpMsub  = 4'd7,
      OpMsubu = 4'd8,
      OpMthi  = 4'd9,
      OpMtlo  = 4'd10
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StFix
   } mdu_state_e;

   // Ops whose operands are two's complement (magnitudes taken, sign fixed up at the end).
   function automatic logic is_signed_op(input mdu_op_e op);
      return (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
   endfunction

   // Ops that run through the multiplier; accumulate forms only when enabled.
   function automatic logic is_mul_op(input mdu_op_e op, input logic acc_en);
      return (op == OpMult) || (op == OpMultu) ||
             (acc_en && ((op == OpMadd) || (op == OpMaddu) ||
                         (op == OpMsub) || (op == OpMsubu)));
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on unsigned WIDTH-bit operands, one quotient bit per cycle.
module mdu_div_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             annul,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             finish
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q;
   logic [CntW-1:0]  cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   trial;
   logic             borrow;

   // One restoring step: shift in the next dividend bit and try to subtract the divisor.
   always_comb begin
      trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
      borrow = trial[WIDTH];
      rem_d  = borrow ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], ~borrow};
   end

   // Iteration registers; start loads, annul abandons the division.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvsr_q <= divisor;
         cnt_q  <= CntW'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (annul) begin
            busy_q <= 1'b0;
         end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               busy_q <= 1'b0;
            end
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign busy      = busy_q;
   // High during the last iteration; results are valid from the next cycle.
   assign finish    = busy_q && (cnt_q == CntW'(1));

endmodule

// File: rtl/mdu_iter_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier with optional
// accumulate, restoring divider, and a sign fix-up cycle before the HI/LO write.
module mdu_iter_unit
   import mdu_iter_unit_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_STEP = 4,
   parameter int unsigned ACC_EN   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             annul,
   output logic             op_ready,
   output logic             stallreq,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned MulIters = WIDTH / MUL_STEP;
   localparam int unsigned CntW     = $clog2(MulIters + 1);

   mdu_state_e state_q, state_d;
   mdu_op_e    op_q, op;

   logic [WIDTH-1:0]          hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]          mcand_q, mplier_q;
   logic [2*WIDTH-1:0]        prod_q, prod_step;
   logic [CntW-1:0]           cnt_q;
   logic                      neg_q, rneg_q, div0_q;

   logic                      is_mul, is_div, is_mt, accept, long_op;
   logic                      a_neg, b_neg, b_zero, div_start;
   logic [WIDTH-1:0]          a_mag, b_mag;
   logic [WIDTH+MUL_STEP-1:0] partial, upper_sum;
   logic [2*WIDTH+MUL_STEP-1:0] shifted;
   logic [2*WIDTH-1:0]        acc, prod_s, fix_res;
   logic [WIDTH-1:0]          quo_s, rem_s;
   logic [WIDTH-1:0]          div_quo, div_rem;
   logic                      div_busy, div_finish;

   // Decode the presented op and form operand magnitudes for the signed variants.
   always_comb begin
      op        = mdu_op_e'(op_code);
      is_mul    = is_mul_op(op, ACC_EN != 0);
      is_div    = (op == OpDiv) || (op == OpDivu);
      is_mt     = (op == OpMthi) || (op == OpMtlo);
      long_op   = is_mul || is_div;
      accept    = op_valid && op_ready && !annul && (long_op || is_mt);
      a_neg     = is_signed_op(op) && src_a[WIDTH-1];
      b_neg     = is_signed_op(op) && src_b[WIDTH-1];
      a_mag     = a_neg ? -src_a : src_a;
      b_mag     = b_neg ? -src_b : src_b;
      b_zero    = (src_b == '0);
      div_start = accept && is_div && !b_zero;
   end

   // One multiplier step: add digit*mcand to the upper half, then shift the pair right.
   always_comb begin
      partial = '0;
      for (int unsigned j = 0; j < MUL_STEP; j++) begin
         if (mplier_q[j]) begin
            partial = partial + ({{MUL_STEP{1'b0}}, mcand_q} << j);
         end
      end
      upper_sum = {{MUL_STEP{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + partial;
      shifted   = {upper_sum, prod_q[WIDTH-1:0]};
      prod_step = shifted[2*WIDTH+MUL_STEP-1:MUL_STEP];
   end

   mdu_div_core #(
      .WIDTH (WIDTH)
   ) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .annul     (annul),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem),
      .busy      (div_busy),
      .finish    (div_finish)
   );

   // Sign fix-up and accumulate: the value HI/LO take when FIX completes.
   always_comb begin
      acc    = {hi_q, lo_q};
      prod_s = neg_q ? -prod_q : prod_q;
      quo_s  = neg_q ? -div_quo : div_quo;
      rem_s  = rneg_q ? -div_rem : div_rem;
      unique case (op_q)
         OpMult, OpMultu: fix_res = prod_s;
         OpMadd, OpMaddu: fix_res = acc + prod_s;
         OpMsub, OpMsubu: fix_res = acc - prod_s;
         OpDiv, OpDivu:   fix_res = div0_q ? acc : {rem_s, quo_s};
         default:         fix_res = acc;
      endcase
   end

   // FSM next state and done; annul anywhere in a long op returns to idle without a write.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept && is_mul) begin
               state_d = StMul;
            end else if (accept && is_div) begin
               state_d = b_zero ? StFix : StDiv;
            end
         end
         StMul: begin
            if (annul) begin
               state_d = StIdle;
            end else if (cnt_q == CntW'(1)) begin
               state_d = StFix;
            end
         end
         StDiv: begin
            if (annul) begin
               state_d = StIdle;
            end else if (div_finish || !div_busy) begin
               state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            done    = !annul;
         end
         default: state_d = StIdle;
      endcase
   end

   // HI/LO next value: MTHI/MTLO write at accept, long ops on the edge leaving FIX.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (accept && (op == OpMthi)) begin
         hi_d = src_a;
      end
      if (accept && (op == OpMtlo)) begin
         lo_d = src_a;
      end
      if ((state_q == StFix) && !annul) begin
         {hi_d, lo_d} = fix_res;
      end
   end

   // State, HI/LO, latched op attributes and multiplier iteration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= OpNop;
         hi_q     <= '0;
         lo_q     <= '0;
         div0_q   <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         if (accept) begin
            op_q   <= op;
            div0_q <= is_div && b_zero;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
         end
         if (accept && is_mul) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            prod_q   <= '0;
            cnt_q    <= CntW'(MulIters);
         end else if (state_q == StMul) begin
            prod_q   <= prod_step;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q - CntW'(1);
         end
      end
   end

   assign op_ready = (state_q == StIdle);
   assign busy     = (state_q != StIdle);
   assign stallreq = busy || (op_valid && op_ready && long_op && !annul);
   assign div0     = div0_q;
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;

endmodule
